// File: rtl/pol2rec_control_pkg.sv
// Shared definitions for the polar-to-rectangular CORDIC control path:
// state encodings and default iteration sizing.
package pol2rec_control_pkg;

   localparam int NITER_DEF = 16;
   localparam int IW_DEF    = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ITER = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/pol2rec_control.sv
// Sequencer for the CORDIC pol2rec datapath: load, NITER rotations,
// then a done pulse with a held out_valid flag.
module pol2rec_control
   import pol2rec_control_pkg::*;
#(
   parameter int NITER = NITER_DEF,
   parameter int IW    = IW_DEF
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   output logic          load,
   output logic          enable,
   output logic [IW-1:0] iter,
   output logic          done,
   output logic          out_valid,
   output logic          busy
);

   localparam logic [IW-1:0] LAST = IW'(NITER - 1);

   state_t        state;
   state_t        state_nxt;
   logic [IW-1:0] count;
   logic [IW-1:0] count_nxt;
   logic          ov_nxt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         count     <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         count     <= count_nxt;
         out_valid <= ov_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      ov_nxt    = out_valid;
      load      = 1'b0;
      enable    = 1'b0;
      done      = 1'b0;
      busy      = 1'b0;
      iter      = '0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = LOAD;
               ov_nxt    = 1'b0;
            end
         end
         LOAD: begin
            load      = 1'b1;
            busy      = 1'b1;
            state_nxt = ITER;
            count_nxt = '0;
         end
         ITER: begin
            enable = 1'b1;
            busy   = 1'b1;
            iter   = count;
            if (count == LAST) begin
               state_nxt = DONE;
               count_nxt = '0;
            end else begin
               count_nxt = count + IW'(1);
            end
         end
         DONE: begin
            done = 1'b1;
            // Results stay flagged valid until the next request is taken
            if (start) begin
               state_nxt = LOAD;
               ov_nxt    = 1'b0;
            end else begin
               state_nxt = IDLE;
               ov_nxt    = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pol2rec_control.sv
// Directed bench for pol2rec_control: cycle table for one conversion
// plus sequences for busy, back-to-back, reset abort, held start, NITER=4.
module tb_pol2rec_control;
   import pol2rec_control_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       load, enable, done, out_valid, busy;
   logic [4:0] iter;
   logic       load4, enable4, done4, out_valid4, busy4;
   logic [1:0] iter4;

   int napplied = 0;
   int nfail    = 0;
   int rst_at   = -1;
   int starts[$];

   int r_ld[64], r_en[64], r_it[64], r_dn[64], r_ov[64], r_bz[64];
   int r4_ld[64], r4_en[64], r4_it[64], r4_dn[64];

   typedef struct {
      logic       start;
      logic       load;
      logic       enable;
      logic [4:0] iter;
      logic       done;
      logic       out_valid;
      logic       busy;
   } vec_t;

   vec_t tbl[20];

   pol2rec_control #(.NITER(16), .IW(5)) dut (
      .clock(clock), .reset(reset), .start(start),
      .load(load), .enable(enable), .iter(iter),
      .done(done), .out_valid(out_valid), .busy(busy)
   );

   pol2rec_control #(.NITER(4), .IW(2)) dut4 (
      .clock(clock), .reset(reset), .start(start),
      .load(load4), .enable(enable4), .iter(iter4),
      .done(done4), .out_valid(out_valid4), .busy(busy4)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input int c,
                      input logic [31:0] act, input logic [31:0] exp);
      napplied++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s cycle=%0d got=%0d want=%0d", name, c, act, exp);
      end
   endtask

   function automatic int has(input int q[$], input int c);
      foreach (q[i]) if (q[i] == c) return 1;
      return 0;
   endfunction

   task automatic chk_idle(input string name);
      chk({name, ".load"}, -1, load, 0);
      chk({name, ".enable"}, -1, enable, 0);
      chk({name, ".iter"}, -1, iter, 0);
      chk({name, ".done"}, -1, done, 0);
      chk({name, ".out_valid"}, -1, out_valid, 0);
      chk({name, ".busy"}, -1, busy, 0);
   endtask

   task automatic do_reset();
      start = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      chk_idle("reset_held");
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk_idle("after_reset");
   endtask

   // Cycle c runs from posedge c to posedge c+1; outputs sampled at its negedge
   task automatic seq(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clock);
         #1;
         if (rst_at >= 0 && c == rst_at + 2) reset = 1'b0;
         start = 1'(has(starts, c));
         @(negedge clock);
         r_ld[c] = int'(load);   r_en[c] = int'(enable);
         r_it[c] = int'(iter);   r_dn[c] = int'(done);
         r_ov[c] = int'(out_valid); r_bz[c] = int'(busy);
         r4_ld[c] = int'(load4); r4_en[c] = int'(enable4);
         r4_it[c] = int'(iter4); r4_dn[c] = int'(done4);
         if (c == rst_at) begin
            #1 reset = 1'b1;
            #1;
            chk_idle("async_reset");
            chk("async_reset.state", c, dut.state, IDLE);
         end
      end
   endtask

   task automatic chk_events(input string name, input int n,
                             input int ld_q[$], input int dn_q[$]);
      for (int c = 0; c < n; c++) begin
         chk({name, ".load"}, c, r_ld[c], has(ld_q, c));
         chk({name, ".done"}, c, r_dn[c], has(dn_q, c));
      end
   endtask

   initial begin
      for (int c = 0; c < 20; c++) begin
         tbl[c] = '{start: (c == 0), load: (c == 1),
                    enable: (c >= 2 && c <= 17),
                    iter: (c >= 2 && c <= 17) ? 5'(c - 2) : 5'd0,
                    done: (c == 18), out_valid: (c == 19),
                    busy: (c >= 1 && c <= 17)};
      end

      // Single conversion, cycle by cycle
      do_reset();
      for (int c = 0; c < 20; c++) begin
         @(posedge clock);
         #1 start = tbl[c].start;
         @(negedge clock);
         chk("single.load", c, load, tbl[c].load);
         chk("single.enable", c, enable, tbl[c].enable);
         chk("single.iter", c, iter, tbl[c].iter);
         chk("single.done", c, done, tbl[c].done);
         chk("single.out_valid", c, out_valid, tbl[c].out_valid);
         chk("single.busy", c, busy, tbl[c].busy);
      end

      // Start pulses while busy are dropped; NITER=4 instance rides along
      do_reset();
      starts = '{0, 5, 12};
      seq(20);
      chk_events("busy", 20, '{1}, '{18});
      chk("busy.out_valid", 19, r_ov[19], 1);
      for (int c = 0; c <= 10; c++) begin
         chk("n4.load", c, r4_ld[c], int'(c == 1));
         chk("n4.enable", c, r4_en[c], int'(c >= 2 && c <= 5));
         chk("n4.iter", c, r4_it[c], (c >= 2 && c <= 5) ? c - 2 : 0);
         chk("n4.done", c, r4_dn[c], int'(c == 6));
      end

      // Start during DONE chains straight into the next load
      do_reset();
      starts = '{0, 18};
      seq(38);
      chk_events("b2b", 38, '{1, 19}, '{18, 36});
      chk("b2b.out_valid", 19, r_ov[19], 0);
      chk("b2b.out_valid", 36, r_ov[36], 0);
      chk("b2b.out_valid", 37, r_ov[37], 1);
      chk("b2b.busy", 19, r_bz[19], 1);

      // Reset mid-conversion; the restart's done follows it by NITER+2 cycles
      do_reset();
      starts = '{0, 12};
      rst_at = 9;
      seq(32);
      rst_at = -1;
      chk("abort.iter_before", 9, r_it[9], 7);
      chk("abort.busy_after", 10, r_bz[10], 0);
      chk_events("abort", 32, '{1, 13}, '{30});

      // Held start: one request per acceptance opportunity
      do_reset();
      starts = {};
      for (int c = 0; c <= 40; c++) starts.push_back(c);
      seq(41);
      chk_events("held", 41, '{1, 19, 37}, '{18, 36});

      $display("== %0d vectors applied, %0d miscompares ==", napplied, nfail);
      $finish;
   end

endmodule
